lt_sequencer: RTL and testbench

- Controls the video generator's latency-test mode.
- On a host trigger it waits for a frame boundary, then drives lt_active/lt_mode so the generator draws the white stimulus box.
- It times how long the photodiode sensor takes to respond, in microseconds, and reports the result, including error and timeout cases.
- It sits between the host/config registers and the video generator, and monitors the generator's VSYNC output.

---
 rtl/lt_sequencer_pkg.sv | 21 ++
 rtl/lt_sensor_sync.sv | 43 ++++
 rtl/lt_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lt_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lt_sequencer_pkg.sv
// Shared definitions for the latency-test sequencer: stimulus position codes,
// error codes and FSM state encoding.
package lt_sequencer_pkg;

    localparam logic [1:0] LT_POS_CENTER    = 2'd0;
    localparam logic [1:0] LT_POS_TOP_LEFT  = 2'd1;
    localparam logic [1:0] LT_POS_TOP_RIGHT = 2'd2;
    localparam logic [1:0] LT_POS_BOTTOM    = 2'd3;

    localparam logic [1:0] LT_ERR_OK      = 2'd0;
    localparam logic [1:0] LT_ERR_SENSOR  = 2'd1;
    localparam logic [1:0] LT_ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StWaitFrame,
        StMeasure,
        StCooldown
    } lt_state_e;

endpackage

// File: rtl/lt_sensor_sync.sv
// Photodiode input conditioning: 2-FF synchronizer followed by a saturating
// run-length counter that qualifies a stable high level.
module lt_sensor_sync #(
    parameter int unsigned SENSOR_STABLE = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sensor_i,
    output logic level_o,
    output logic sens_ok_o
);

    localparam int unsigned CW = $clog2(SENSOR_STABLE + 1);
    localparam logic [CW-1:0] CntMax = CW'(SENSOR_STABLE - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], sensor_i};
            cnt_q  <= cnt_d;
        end
    end

    // cnt_q holds the number of preceding consecutive highs, so the current
    // sample is the SENSOR_STABLE-th one when cnt_q reaches CntMax.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync_q[1]) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign level_o   = sync_q[1];
    assign sens_ok_o = sync_q[1] && (cnt_q == CntMax);

endmodule

// File: rtl/lt_sequencer.sv
// Latency-test sequencer: on a host trigger, arms the stimulus at the next
// frame boundary and times the photodiode response in microseconds.
module lt_sequencer
    import lt_sequencer_pkg::*;
#(
    parameter int unsigned CLKS_PER_US     = 27,
    parameter int unsigned SENSOR_STABLE   = 16,
    parameter logic [15:0] TIMEOUT_US      = 16'd50000,
    parameter int unsigned COOLDOWN_FRAMES = 4
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic        lt_trigger,
    input  logic [1:0]  lt_mode_cfg,
    input  logic        vsync_in,
    input  logic        sensor_in,
    output logic        lt_active,
    output logic [1:0]  lt_mode,
    output logic        lt_busy,
    output logic        lt_done,
    output logic [15:0] lt_result,
    output logic [1:0]  lt_error
);

    localparam int unsigned PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int unsigned FW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [PW-1:0] PrescMax = PW'(CLKS_PER_US - 1);
    localparam logic [FW-1:0] FrmMax   = FW'(COOLDOWN_FRAMES);

    lt_state_e     state_q, state_d;
    logic          vsync_q;
    logic          active_q, active_d;
    logic [1:0]    mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   result_q, result_d;
    logic [1:0]    error_q, error_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   us_q, us_d;
    logic [FW-1:0] frm_q, frm_d;

    logic sens_level;
    logic sens_ok;
    logic vsync_fall;

    lt_sensor_sync #(
        .SENSOR_STABLE (SENSOR_STABLE)
    ) u_sensor_sync (
        .clk_i     (clk27),
        .rst_ni    (reset_n),
        .sensor_i  (sensor_in),
        .level_o   (sens_level),
        .sens_ok_o (sens_ok)
    );

    assign vsync_fall = vsync_q && !vsync_in;

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            vsync_q  <= 1'b0;
            active_q <= 1'b0;
            mode_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            error_q  <= LT_ERR_OK;
            presc_q  <= '0;
            us_q     <= '0;
            frm_q    <= '0;
        end else begin
            state_q  <= state_d;
            vsync_q  <= vsync_in;
            active_q <= active_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            error_q  <= error_d;
            presc_q  <= presc_d;
            us_q     <= us_d;
            frm_q    <= frm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        error_d  = error_q;
        presc_d  = presc_q;
        us_d     = us_q;
        frm_d    = frm_q;

        unique case (state_q)
            StIdle: begin
                if (lt_trigger) begin
                    if (sens_level) begin
                        error_d  = LT_ERR_SENSOR;
                        result_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        mode_d  = lt_mode_cfg;
                        busy_d  = 1'b1;
                        error_d = LT_ERR_OK;
                        state_d = StWaitFrame;
                    end
                end
            end
            StWaitFrame: begin
                if (vsync_fall) begin
                    active_d = 1'b1;
                    presc_d  = '0;
                    us_d     = '0;
                    state_d  = StMeasure;
                end
            end
            StMeasure: begin
                if (presc_q == PrescMax) begin
                    presc_d = '0;
                    if (us_q != 16'hFFFF) begin
                        us_d = us_q + 16'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                // A detection in the timeout cycle still reports a valid latency.
                if (sens_ok) begin
                    result_d = us_q;
                    error_d  = LT_ERR_OK;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    frm_d    = '0;
                    state_d  = StCooldown;
                end else if (us_q >= TIMEOUT_US) begin
                    result_d = 16'hFFFF;
                    error_d  = LT_ERR_TIMEOUT;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    frm_d    = '0;
                    state_d  = StCooldown;
                end
            end
            StCooldown: begin
                if (frm_q == FrmMax) begin
                    frm_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (sens_level) begin
                    frm_d = '0;
                end else if (vsync_fall) begin
                    frm_d = frm_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign lt_active = active_q;
    assign lt_mode   = mode_q;
    assign lt_busy   = busy_q;
    assign lt_done   = done_q;
    assign lt_result = result_q;
    assign lt_error  = error_q;

endmodule

// File: tb/tb_lt_sequencer.sv
// Scoreboard bench for lt_sequencer: directed runs push expected results,
// a monitor pops and compares on every lt_done pulse.
module tb_lt_sequencer;
    import lt_sequencer_pkg::*;

    localparam logic [15:0] TB_TIMEOUT = 16'd300;

    logic        clk27;
    logic        reset_n;
    logic        lt_trigger;
    logic [1:0]  lt_mode_cfg;
    logic        vsync_in;
    logic        sensor_in;
    logic        lt_active;
    logic [1:0]  lt_mode;
    logic        lt_busy;
    logic        lt_done;
    logic [15:0] lt_result;
    logic [1:0]  lt_error;

    typedef struct packed {
        logic [15:0] result;
        logic [1:0]  error;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    int   n_cmp = 0;
    int   n_err = 0;

    lt_sequencer #(
        .CLKS_PER_US     (27),
        .SENSOR_STABLE   (16),
        .TIMEOUT_US      (TB_TIMEOUT),
        .COOLDOWN_FRAMES (4)
    ) dut (
        .clk27       (clk27),
        .reset_n     (reset_n),
        .lt_trigger  (lt_trigger),
        .lt_mode_cfg (lt_mode_cfg),
        .vsync_in    (vsync_in),
        .sensor_in   (sensor_in),
        .lt_active   (lt_active),
        .lt_mode     (lt_mode),
        .lt_busy     (lt_busy),
        .lt_done     (lt_done),
        .lt_result   (lt_result),
        .lt_error    (lt_error)
    );

    initial clk27 = 1'b0;
    always #5 clk27 = ~clk27;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk27) begin
        if (lt_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got result %0h error %0h expected no pulse",
                         lt_result, lt_error);
            end else begin
                exp_e = exp_q.pop_front();
                check("done_result", 32'(lt_result), 32'(exp_e.result));
                check("done_error", 32'(lt_error), 32'(exp_e.error));
                check("done_active_low", 32'(lt_active), 32'd0);
            end
        end
    end

    task automatic trigger(input logic [1:0] cfg);
        @(posedge clk27); #1;
        lt_mode_cfg = cfg;
        lt_trigger  = 1'b1;
        @(posedge clk27); #1;
        lt_trigger  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk27);
            if (lt_done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no lt_done expected pulse within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic pulse_vsync();
        @(posedge clk27); #1;
        vsync_in = 1'b0;
        repeat (3) @(posedge clk27);
        #1 vsync_in = 1'b1;
        repeat (6) @(posedge clk27);
    endtask

    // Single-cycle vsync fall; returns at the negedge of the first counted cycle.
    task automatic start_measure(input string name);
        @(posedge clk27); #1;
        vsync_in = 1'b0;
        @(negedge clk27);
        check({name, "_active_before"}, 32'(lt_active), 32'd0);
        @(posedge clk27); #1;
        vsync_in = 1'b1;
        @(negedge clk27);
        check({name, "_active_after"}, 32'(lt_active), 32'd1);
    endtask

    task automatic cooldown_clear(input string name);
        @(posedge clk27); #1;
        sensor_in = 1'b0;
        repeat (4) @(posedge clk27);
        repeat (4) pulse_vsync();
        @(negedge clk27);
        check({name, "_busy_cleared"}, 32'(lt_busy), 32'd0);
    endtask

    initial begin
        int n;
        reset_n     = 1'b1;
        lt_trigger  = 1'b0;
        lt_mode_cfg = LT_POS_CENTER;
        vsync_in    = 1'b1;
        sensor_in   = 1'b0;
        #1 reset_n  = 1'b0;
        repeat (3) @(negedge clk27);
        check("rst_active", 32'(lt_active), 32'd0);
        check("rst_busy", 32'(lt_busy), 32'd0);
        check("rst_done", 32'(lt_done), 32'd0);
        check("rst_result", 32'(lt_result), 32'd0);
        check("rst_error", 32'(lt_error), 32'd0);
        check("rst_mode", 32'(lt_mode), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk27);

        // Sensor already lit at trigger
        #1 sensor_in = 1'b1;
        repeat (5) @(posedge clk27);
        exp_q.push_back('{result: 16'd0, error: LT_ERR_SENSOR});
        trigger(LT_POS_TOP_LEFT);
        wait_done("sensor_high_done", 2);
        repeat (3) @(negedge clk27);
        check("sensor_high_busy", 32'(lt_busy), 32'd0);
        check("sensor_high_active", 32'(lt_active), 32'd0);

        // Nominal run: 2700 cycles -> 100 us
        @(posedge clk27); #1 sensor_in = 1'b0;
        repeat (20) @(posedge clk27);
        trigger(LT_POS_TOP_RIGHT);
        lt_mode_cfg = LT_POS_BOTTOM;
        @(negedge clk27);
        check("nominal_error_cleared", 32'(lt_error), 32'(LT_ERR_OK));
        repeat (1000) @(posedge clk27);
        @(negedge clk27);
        check("nominal_busy", 32'(lt_busy), 32'd1);
        check("wait_frame_active", 32'(lt_active), 32'd0);
        start_measure("nominal");
        check("mode_latched", 32'(lt_mode), 32'(LT_POS_TOP_RIGHT));
        exp_q.push_back('{result: 16'd100, error: LT_ERR_OK});
        repeat (2700) @(posedge clk27);
        #1 sensor_in = 1'b1;
        wait_done("nominal_done", 100);
        @(negedge clk27);
        check("nominal_active_after", 32'(lt_active), 32'd0);
        check("nominal_busy_after", 32'(lt_busy), 32'd1);

        // Cooldown: sensor high frames do not count, triggers ignored
        repeat (2) pulse_vsync();
        trigger(LT_POS_CENTER);
        @(negedge clk27);
        check("cool_busy_hi", 32'(lt_busy), 32'd1);
        check("cool_result_held", 32'(lt_result), 32'd100);
        @(posedge clk27); #1 sensor_in = 1'b0;
        repeat (4) @(posedge clk27);
        repeat (3) pulse_vsync();
        trigger(LT_POS_CENTER);
        @(negedge clk27);
        check("cool_busy_3frames", 32'(lt_busy), 32'd1);
        check("cool_mode_unchanged", 32'(lt_mode), 32'(LT_POS_TOP_RIGHT));
        pulse_vsync();
        @(negedge clk27);
        check("cool_busy_4frames", 32'(lt_busy), 32'd0);

        // Glitch rejection: 10-cycle pulse ignored, stable rise at 5400 -> 200 us
        trigger(LT_POS_BOTTOM);
        @(negedge clk27);
        check("retrigger_busy", 32'(lt_busy), 32'd1);
        check("retrigger_mode", 32'(lt_mode), 32'(LT_POS_BOTTOM));
        start_measure("glitch");
        exp_q.push_back('{result: 16'd200, error: LT_ERR_OK});
        repeat (1000) @(posedge clk27);
        #1 sensor_in = 1'b1;
        repeat (10) @(posedge clk27);
        #1 sensor_in = 1'b0;
        repeat (4390) @(posedge clk27);
        #1 sensor_in = 1'b1;
        wait_done("glitch_done", 100);
        cooldown_clear("glitch");

        // Timeout after TB_TIMEOUT us of counted cycles
        trigger(LT_POS_CENTER);
        start_measure("timeout");
        exp_q.push_back('{result: 16'hFFFF, error: LT_ERR_TIMEOUT});
        n = 0;
        while (lt_done !== 1'b1 && n < 9000) begin
            @(negedge clk27);
            n++;
        end
        n_cmp++;
        if (n < 8099 || n > 8101) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d cycles expected 8100 +/- 1", n);
        end
        cooldown_clear("timeout");

        // Asynchronous reset during MEASURE
        trigger(LT_POS_TOP_LEFT);
        start_measure("reset");
        repeat (100) @(negedge clk27);
        check("reset_pre_active", 32'(lt_active), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_async_active", 32'(lt_active), 32'd0);
        check("reset_async_busy", 32'(lt_busy), 32'd0);
        check("reset_async_result", 32'(lt_result), 32'd0);
        check("reset_async_done", 32'(lt_done), 32'd0);
        repeat (3) @(negedge clk27);
        reset_n = 1'b1;
        repeat (5) @(negedge clk27);
        trigger(LT_POS_TOP_RIGHT);
        @(negedge clk27);
        check("post_reset_accept", 32'(lt_busy), 32'd1);
        repeat (10) @(negedge clk27);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
